// File: rtl/wisc_pkg.sv
// Shared constants for the WISC core datapath.
// Register-file geometry and the hardwired-zero register index.
package wisc_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = 4'h0;
endpackage

// File: rtl/reg_cell.sv
// Single architectural register: synchronous active-low clear, load on write enable.
// Clear takes priority over a concurrent write.
module reg_cell
    import wisc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/reg_file.sv
// 16x16 register file, two combinational read ports, one write port, R0 hardwired zero.
// Same-cycle write data is forwarded to matching read ports (write-before-read).
module reg_file
    import wisc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] src_reg1,
    input  logic [ADDR_W-1:0] src_reg2,
    input  logic [ADDR_W-1:0] dst_reg,
    input  logic              write_reg,
    input  logic [DATA_W-1:0] dst_data,
    output logic [DATA_W-1:0] src_data1,
    output logic [DATA_W-1:0] src_data2
);

    logic [DATA_W-1:0] w_q [NUM_REGS];
    logic              w_wr_live;
    logic              w_byp1;
    logic              w_byp2;

    // R0 has no storage; it is a constant.
    assign w_q[0] = '0;

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_cell
            logic w_we;
            assign w_we = write_reg && (dst_reg == ADDR_W'(g));

            reg_cell u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .i_we  (w_we),
                .i_d   (dst_data),
                .o_q   (w_q[g])
            );
        end
    endgenerate

    // A write to R0 is discarded, so it must never be forwarded either.
    assign w_wr_live = write_reg && (dst_reg != REG_ZERO);
    assign w_byp1    = w_wr_live && (dst_reg == src_reg1);
    assign w_byp2    = w_wr_live && (dst_reg == src_reg2);

    always_comb begin
        src_data1 = w_q[src_reg1];
        src_data2 = w_q[src_reg2];
        if (w_byp1) begin
            src_data1 = dst_data;
        end
        if (w_byp2) begin
            src_data2 = dst_data;
        end
        if (!rst_n) begin
            src_data1 = '0;
            src_data2 = '0;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed scenarios plus randomized traffic against an array model.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  src_reg1;
    logic [3:0]  src_reg2;
    logic [3:0]  dst_reg;
    logic        write_reg;
    logic [15:0] dst_data;
    logic [15:0] src_data1;
    logic [15:0] src_data2;

    logic [15:0] model [16];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    reg_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_reg1  (src_reg1),
        .src_reg2  (src_reg2),
        .dst_reg   (dst_reg),
        .write_reg (write_reg),
        .dst_data  (dst_data),
        .src_data1 (src_data1),
        .src_data2 (src_data2)
    );

    // Architectural view of a read given the current inputs.
    function automatic logic [15:0] ref_read(input logic [3:0] idx);
        if (!rst_n || idx == 4'd0) return 16'h0000;
        if (write_reg && dst_reg == idx) return dst_data;
        return model[idx];
    endfunction

    // Advance one clock, applying the same edge to the model.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) model[k] = 16'h0000;
        end else if (write_reg && dst_reg != 4'd0) begin
            model[dst_reg] = dst_data;
        end
        #2;
    endtask

    task automatic wr(input logic [3:0] r, input logic [15:0] d);
        write_reg = 1'b1;
        dst_reg   = r;
        dst_data  = d;
        tick();
        write_reg = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        write_reg = 1'b1;
        dst_reg   = 4'd3;
        dst_data  = 16'hBEEF;
        src_reg1  = 4'd3;
        src_reg2  = 4'd3;
        tick();
        #1;
        n_tests++;
        if (src_data1 !== 16'h0000 || src_data2 !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_forced: got %h/%h expected 0000/0000", src_data1, src_data2);
        end
        tick();
        rst_n     = 1'b1;
        write_reg = 1'b0;
        for (int i = 0; i < 16; i++) begin
            src_reg1 = 4'(i);
            src_reg2 = 4'(15 - i);
            #1;
            n_tests++;
            if (src_data1 !== 16'h0000 || src_data2 !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_clear r%0d: got %h/%h expected 0000/0000", i, src_data1, src_data2);
            end
        end
    endtask

    task automatic test_write_read();
        wr(4'd5, 16'h1234);
        src_reg1 = 4'd5;
        src_reg2 = 4'd6;
        #1;
        n_tests++;
        if (src_data1 !== 16'h1234) begin
            n_fail++;
            $display("FAIL write_read r5: got %h expected 1234", src_data1);
        end
        n_tests++;
        if (src_data2 !== 16'h0000) begin
            n_fail++;
            $display("FAIL write_read r6: got %h expected 0000", src_data2);
        end
    endtask

    task automatic test_r0();
        write_reg = 1'b1;
        dst_reg   = 4'd0;
        dst_data  = 16'hFFFF;
        src_reg1  = 4'd0;
        src_reg2  = 4'd0;
        #1;
        n_tests++;
        if (src_data1 !== 16'h0000 || src_data2 !== 16'h0000) begin
            n_fail++;
            $display("FAIL r0_same_cycle: got %h/%h expected 0000/0000", src_data1, src_data2);
        end
        tick();
        write_reg = 1'b0;
        #1;
        n_tests++;
        if (src_data1 !== 16'h0000) begin
            n_fail++;
            $display("FAIL r0_next_cycle: got %h expected 0000", src_data1);
        end
    endtask

    task automatic test_bypass();
        wr(4'd7, 16'h00AA);
        write_reg = 1'b1;
        dst_reg   = 4'd7;
        dst_data  = 16'h5555;
        src_reg1  = 4'd7;
        src_reg2  = 4'd7;
        #1;
        n_tests++;
        if (src_data1 !== 16'h5555 || src_data2 !== 16'h5555) begin
            n_fail++;
            $display("FAIL bypass_both: got %h/%h expected 5555/5555", src_data1, src_data2);
        end
        tick();
        // Disabled write must neither forward nor store.
        write_reg = 1'b0;
        dst_data  = 16'h1234;
        #1;
        n_tests++;
        if (src_data1 !== 16'h5555 || src_data2 !== 16'h5555) begin
            n_fail++;
            $display("FAIL no_bypass_wr0: got %h/%h expected 5555/5555", src_data1, src_data2);
        end
        tick();
        #1;
        n_tests++;
        if (src_data1 !== 16'h5555) begin
            n_fail++;
            $display("FAIL wr0_no_store: got %h expected 5555", src_data1);
        end
    endtask

    task automatic test_reset_mid();
        wr(4'd9, 16'h0F0F);
        rst_n     = 1'b0;
        write_reg = 1'b1;
        dst_reg   = 4'd9;
        dst_data  = 16'h1111;
        tick();
        rst_n     = 1'b1;
        write_reg = 1'b0;
        src_reg1  = 4'd9;
        src_reg2  = 4'd7;
        #1;
        n_tests++;
        if (src_data1 !== 16'h0000 || src_data2 !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid: got %h/%h expected 0000/0000", src_data1, src_data2);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] e1, e2;
        for (int i = 1; i < 16; i++) wr(4'(i), 16'(i * 16'h1111));
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                src_reg1 = 4'(i);
                src_reg2 = 4'(j);
                e1 = 16'(i * 16'h1111);
                e2 = 16'(j * 16'h1111);
                #1;
                n_tests++;
                if (src_data1 !== e1 || src_data2 !== e2) begin
                    n_fail++;
                    $display("FAIL sweep r%0d/r%0d: got %h/%h expected %h/%h", i, j, src_data1, src_data2, e1, e2);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] e1, e2;
        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            write_reg = $urandom_range(0, 3) != 0;
            dst_reg   = 4'($urandom_range(0, 15));
            dst_data  = 16'($urandom);
            // Bias reads toward the write target to exercise forwarding.
            src_reg1  = ($urandom_range(0, 2) == 0) ? dst_reg : 4'($urandom_range(0, 15));
            src_reg2  = ($urandom_range(0, 2) == 0) ? dst_reg : 4'($urandom_range(0, 15));
            #1;
            e1 = ref_read(src_reg1);
            e2 = ref_read(src_reg2);
            n_tests++;
            if (src_data1 !== e1 || src_data2 !== e2) begin
                n_fail++;
                $display("FAIL random #%0d rd r%0d/r%0d: got %h/%h expected %h/%h",
                         n, src_reg1, src_reg2, src_data1, src_data2, e1, e2);
            end
            tick();
        end
        rst_n = 1'b1;
        write_reg = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) model[k] = 16'h0000;
        rst_n     = 1'b0;
        write_reg = 1'b0;
        dst_reg   = 4'd0;
        dst_data  = 16'h0000;
        src_reg1  = 4'd0;
        src_reg2  = 4'd0;
        test_reset();
        test_write_read();
        test_r0();
        test_bypass();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
